// File: rtl/systolic_feeder_pkg.sv
// Shared systolic types: feeder state enum, default array geometry, counter sizing.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: feeder_state_e (IDLE/STREAM/FLUSH), SYS_N, SYS_DATA_W, cnt_w().
package systolic_feeder_pkg;

  // Default array edge width and operand width, shared with the PE array and drain.
  localparam int SYS_N      = 4;
  localparam int SYS_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2
  } feeder_state_e;

  // Width needed to hold a beat count in the range 0..max_k.
  function automatic int cnt_w(input int max_k);
    return $clog2(max_k + 1);
  endfunction

endpackage

// File: rtl/systolic_feeder_if.sv
// Handshake and lane bus between an operand source, the feeder and the array edge.
// Latency: n/a (wiring only).
// Backpressure: in_ready from the feeder throttles the in_valid source.
// Ports: master = upstream side (drives in_*), slave = feeder side (drives in_ready, lane_*, status).
interface systolic_feeder_if
  import systolic_feeder_pkg::*;
#(
  parameter int N      = SYS_N,
  parameter int DATA_W = SYS_DATA_W,
  parameter int MAX_K  = 256
);
  localparam int CNT_W = cnt_w(MAX_K);

  logic                  in_valid;
  logic                  in_ready;
  logic [N*DATA_W-1:0]   in_data;
  logic                  in_last;
  logic [N-1:0]          lane_valid;
  logic [N*DATA_W-1:0]   lane_data;
  logic                  busy;
  logic                  done;
  logic [CNT_W-1:0]      beat_count;
  logic                  err_overflow;

  modport master (
    output in_valid, in_data, in_last,
    input  in_ready, lane_valid, lane_data, busy, done, beat_count, err_overflow
  );

  modport slave (
    input  in_valid, in_data, in_last,
    output in_ready, lane_valid, lane_data, busy, done, beat_count, err_overflow
  );

endinterface

// File: rtl/systolic_feeder_skew_lane.sv
// One skew lane: delays a data word and its valid bit together by DEPTH cycles.
// Latency: DEPTH cycles from push to tap.
// Backpressure: none; the lane shifts every cycle.
// Ports: clk, rst (sync, active-high), push_vld/push_dat in, tap_vld/tap_dat out.
module skew_lane
  import systolic_feeder_pkg::*;
#(
  parameter int DEPTH  = 1,
  parameter int DATA_W = SYS_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_vld,
  input  logic [DATA_W-1:0] push_dat,
  output logic              tap_vld,
  output logic [DATA_W-1:0] tap_dat
);

  logic [DEPTH-1:0]             vld_q;
  logic [DEPTH-1:0][DATA_W-1:0] dat_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      dat_q <= '0;
    end else begin
      vld_q[0] <= push_vld;
      dat_q[0] <= push_dat;
      for (int s = 1; s < DEPTH; s++) begin
        vld_q[s] <= vld_q[s-1];
        dat_q[s] <= dat_q[s-1];
      end
    end
  end

  assign tap_vld = vld_q[DEPTH-1];
  assign tap_dat = dat_q[DEPTH-1];

endmodule

// File: rtl/systolic_feeder.sv
// Operand feeder: skews each accepted vector so lane i reaches the array edge i cycles after lane 0.
// Latency: lane i presents a beat 1+i cycles after acceptance; done N cycles after the last beat.
// Backpressure: in_ready drops for the N flush cycles after a tile's last beat, independent of in_valid.
// Ports: clk, rst (sync, active-high), bus (slave modport: in_* handshake, lane_* outputs, busy/done/beat_count/err_overflow).
module systolic_feeder
  import systolic_feeder_pkg::*;
#(
  parameter int N      = SYS_N,
  parameter int DATA_W = SYS_DATA_W,
  parameter int MAX_K  = 256
) (
  input logic               clk,
  input logic               rst,
  systolic_feeder_if.slave  bus
);

  localparam int CNT_W = cnt_w(MAX_K);
  localparam int FC_W  = (N > 1) ? $clog2(N) : 1;

  feeder_state_e              state;
  logic [FC_W-1:0]            flush_cnt;
  logic                       done_q;
  logic [CNT_W-1:0]           beat_cnt;
  logic                       err_q;
  logic                       ready;
  logic                       accept;
  logic [N-1:0]               lane_vld;
  logic [N-1:0][DATA_W-1:0]   lane_dat;

  // Ready comes from state alone so it never loops back through in_valid.
  assign ready  = (state != FLUSH);
  assign accept = bus.in_valid && ready;

  // Bubbles enter the lanes as zero data so the array edge sees clean zeros.
  for (genvar i = 0; i < N; i++) begin : g_lane
    skew_lane #(
      .DEPTH  (i + 1),
      .DATA_W (DATA_W)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .push_vld (accept),
      .push_dat (accept ? bus.in_data[i*DATA_W +: DATA_W] : {DATA_W{1'b0}}),
      .tap_vld  (lane_vld[i]),
      .tap_dat  (lane_dat[i])
    );
  end

  // FLUSH spans N cycles: flush_cnt runs N-1 down to 0, and done fires on
  // the cycle the counter reads 0, when lane N-1 carries the last beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      flush_cnt <= '0;
      done_q    <= 1'b0;
      beat_cnt  <= '0;
      err_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE, STREAM: begin
          if (accept) begin
            if (state == IDLE) begin
              beat_cnt <= CNT_W'(1);
            end else if (beat_cnt == CNT_W'(MAX_K)) begin
              err_q <= 1'b1;        // saturate; the beat itself is still forwarded
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
            if (bus.in_last) begin
              state     <= FLUSH;
              flush_cnt <= FC_W'(N - 1);
              done_q    <= (N == 1);
            end else begin
              state <= STREAM;
            end
          end
        end
        FLUSH: begin
          if (flush_cnt == '0) begin
            state <= IDLE;
          end else begin
            flush_cnt <= flush_cnt - 1'b1;
            done_q    <= (flush_cnt == FC_W'(1));
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready     = ready;
  assign bus.lane_valid   = lane_vld;
  assign bus.lane_data    = lane_dat;
  assign bus.busy         = (state != IDLE);
  assign bus.done         = done_q;
  assign bus.beat_count   = beat_cnt;
  assign bus.err_overflow = err_q;

endmodule

// File: tb/tb_systolic_feeder.sv
// Bench for systolic_feeder: two instances (MAX_K=256 and MAX_K=4) share one stimulus stream.
// Lane outputs are scored against a queue of accepted beats; status outputs are checked inline per scenario.
module tb_systolic_feeder;
  import systolic_feeder_pkg::*;

  localparam int N  = 4;
  localparam int DW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            tb_rst   = 1'b1;
  logic            tb_valid = 1'b0;
  logic            tb_last  = 1'b0;
  logic [N*DW-1:0] tb_data  = '0;

  int n_tests = 0;
  int n_fail  = 0;
  bit sb_on   = 1'b0;

  systolic_feeder_if #(.N(N), .DATA_W(DW), .MAX_K(256)) bus_a ();
  systolic_feeder_if #(.N(N), .DATA_W(DW), .MAX_K(4))   bus_b ();

  assign bus_a.in_valid = tb_valid;
  assign bus_a.in_data  = tb_data;
  assign bus_a.in_last  = tb_last;
  assign bus_b.in_valid = tb_valid;
  assign bus_b.in_data  = tb_data;
  assign bus_b.in_last  = tb_last;

  systolic_feeder #(.N(N), .DATA_W(DW), .MAX_K(256)) dut_a (.clk(clk), .rst(tb_rst), .bus(bus_a));
  systolic_feeder #(.N(N), .DATA_W(DW), .MAX_K(4))   dut_b (.clk(clk), .rst(tb_rst), .bus(bus_b));

  // Scoreboard: one entry per clock edge, holding what the bench expects to be accepted there.
  typedef struct packed {
    logic            vld;
    logic [N*DW-1:0] dat;
  } ent_t;

  ent_t exp_q[$];
  ent_t hist[N];

  function automatic logic [N*DW-1:0] pack4(input int a, input int b, input int c, input int d);
    return {d[7:0], c[7:0], b[7:0], a[7:0]};
  endfunction

  // Drive one cycle of input and record whether the bench expects it accepted.
  task automatic cyc(input logic v, input logic [N*DW-1:0] d, input logic l, input logic acc);
    ent_t e;
    tb_valid = v;
    tb_data  = d;
    tb_last  = l;
    e.vld    = acc;
    e.dat    = acc ? d : '0;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle();
    cyc(1'b0, '0, 1'b0, 1'b0);
  endtask

  // hist[k] is the beat accepted k edges ago; lane i must show hist[i] lane i.
  always @(posedge clk) begin
    ent_t            e;
    logic            exp_v;
    logic [DW-1:0]   exp_d;
    e = '0;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    if (tb_rst) begin
      for (int i = 0; i < N; i++) hist[i] = '0;
    end else begin
      for (int i = N - 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = e;
    end
    #2;
    if (sb_on) begin
      for (int i = 0; i < N; i++) begin
        exp_v = hist[i].vld;
        exp_d = hist[i].dat[i*DW +: DW];
        n_tests++;
        if (bus_a.lane_valid[i] !== exp_v || bus_a.lane_data[i*DW +: DW] !== exp_d) begin
          n_fail++;
          $display("FAIL lane%0d_a @%0t: got v=%b d=%0d, want v=%b d=%0d", i, $time,
                   bus_a.lane_valid[i], bus_a.lane_data[i*DW +: DW], exp_v, exp_d);
        end
        n_tests++;
        if (bus_b.lane_valid[i] !== exp_v || bus_b.lane_data[i*DW +: DW] !== exp_d) begin
          n_fail++;
          $display("FAIL lane%0d_b @%0t: got v=%b d=%0d, want v=%b d=%0d", i, $time,
                   bus_b.lane_valid[i], bus_b.lane_data[i*DW +: DW], exp_v, exp_d);
        end
      end
    end
  end

  task automatic test_reset();
    tb_rst = 1'b1;
    idle();
    idle();
    tb_rst = 1'b0;
    sb_on  = 1'b1;
    n_tests++;
    if (bus_a.lane_valid !== '0 || bus_a.lane_data !== '0 || bus_a.done !== 1'b0 ||
        bus_a.busy !== 1'b0 || bus_a.beat_count !== '0 || bus_a.err_overflow !== 1'b0 ||
        bus_a.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_a: lv=%b ld=%h done=%b busy=%b cnt=%0d err=%b rdy=%b, want 0 0 0 0 0 0 1",
               bus_a.lane_valid, bus_a.lane_data, bus_a.done, bus_a.busy, bus_a.beat_count,
               bus_a.err_overflow, bus_a.in_ready);
    end
    n_tests++;
    if (bus_b.busy !== 1'b0 || bus_b.beat_count !== '0 || bus_b.err_overflow !== 1'b0 ||
        bus_b.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_b: busy=%b cnt=%0d err=%b rdy=%b, want 0 0 0 1",
               bus_b.busy, bus_b.beat_count, bus_b.err_overflow, bus_b.in_ready);
    end
  endtask

  task automatic test_back_to_back();
    cyc(1'b1, pack4(1, 2, 3, 4), 1'b0, 1'b1);
    n_tests++;
    if (bus_a.busy !== 1'b1 || bus_a.in_ready !== 1'b1 || bus_a.beat_count !== 9'd1) begin
      n_fail++;
      $display("FAIL b2b_stream: busy=%b rdy=%b cnt=%0d, want 1 1 1",
               bus_a.busy, bus_a.in_ready, bus_a.beat_count);
    end
    cyc(1'b1, pack4(5, 6, 7, 8), 1'b0, 1'b1);
    cyc(1'b1, pack4(9, 10, 11, 12), 1'b1, 1'b1);
    // Now in cycle t+3 (beat 1 accepted at t).
    for (int k = 3; k <= 7; k++) begin
      if (k > 3) idle();
      n_tests++;
      if (bus_a.done !== (k == 6) || bus_a.in_ready !== (k == 7) || bus_a.busy !== (k <= 6) ||
          bus_b.done !== (k == 6)) begin
        n_fail++;
        $display("FAIL b2b_flush t+%0d: done=%b/%b rdy=%b busy=%b, want done=%b rdy=%b busy=%b",
                 k, bus_a.done, bus_b.done, bus_a.in_ready, bus_a.busy, (k == 6), (k == 7), (k <= 6));
      end
      if (k == 3) begin
        n_tests++;
        if (bus_a.lane_data[7:0] !== 8'd9) begin
          n_fail++;
          $display("FAIL b2b_lane0_t3: got %0d, want 9", bus_a.lane_data[7:0]);
        end
      end
      if (k == 6) begin
        n_tests++;
        if (bus_a.lane_data[31:24] !== 8'd12 || bus_a.lane_valid[3] !== 1'b1) begin
          n_fail++;
          $display("FAIL b2b_lane3_t6: got v=%b d=%0d, want v=1 d=12",
                   bus_a.lane_valid[3], bus_a.lane_data[31:24]);
        end
      end
    end
    n_tests++;
    if (bus_a.beat_count !== 9'd3 || bus_b.beat_count !== 3'd3) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d/%0d, want 3", bus_a.beat_count, bus_b.beat_count);
    end
  endtask

  task automatic test_bubble();
    cyc(1'b1, pack4(1, 2, 3, 4), 1'b0, 1'b1);
    cyc(1'b0, pack4(99, 99, 99, 99), 1'b0, 1'b0);
    n_tests++;
    if (bus_a.lane_valid[0] !== 1'b0 || bus_a.lane_data[7:0] !== 8'd0) begin
      n_fail++;
      $display("FAIL bubble_lane0: got v=%b d=%0d, want v=0 d=0",
               bus_a.lane_valid[0], bus_a.lane_data[7:0]);
    end
    cyc(1'b1, pack4(5, 6, 7, 8), 1'b0, 1'b1);
    cyc(1'b1, pack4(9, 10, 11, 12), 1'b1, 1'b1);
    // Last beat accepted at t+3; done expected at t+7.
    for (int j = 1; j <= N + 1; j++) begin
      if (j > 1) idle();
      n_tests++;
      if (bus_a.done !== (j == N) || bus_a.in_ready !== (j > N) || bus_a.busy !== (j <= N)) begin
        n_fail++;
        $display("FAIL bubble_flush j=%0d: done=%b rdy=%b busy=%b, want %b %b %b",
                 j, bus_a.done, bus_a.in_ready, bus_a.busy, (j == N), (j > N), (j <= N));
      end
    end
    n_tests++;
    if (bus_a.beat_count !== 9'd3) begin
      n_fail++;
      $display("FAIL bubble_count: got %0d, want 3", bus_a.beat_count);
    end
  endtask

  task automatic test_single_neg();
    cyc(1'b1, pack4(-1, -2, -3, -4), 1'b1, 1'b1);
    for (int j = 1; j <= N + 1; j++) begin
      if (j > 1) idle();
      n_tests++;
      if (bus_a.done !== (j == N) || bus_a.in_ready !== (j > N) || bus_a.busy !== (j <= N)) begin
        n_fail++;
        $display("FAIL single_flush j=%0d: done=%b rdy=%b busy=%b, want %b %b %b",
                 j, bus_a.done, bus_a.in_ready, bus_a.busy, (j == N), (j > N), (j <= N));
      end
    end
    n_tests++;
    if (bus_a.beat_count !== 9'd1) begin
      n_fail++;
      $display("FAIL single_count: got %0d, want 1", bus_a.beat_count);
    end
  endtask

  task automatic test_flush_hold();
    cyc(1'b1, pack4(13, 14, 15, 16), 1'b0, 1'b1);
    cyc(1'b1, pack4(17, 18, 19, 20), 1'b1, 1'b1);
    // New data held valid throughout FLUSH must not be taken.
    for (int j = 1; j <= N; j++) begin
      n_tests++;
      if (bus_a.in_ready !== 1'b0 || bus_a.done !== (j == N)) begin
        n_fail++;
        $display("FAIL hold_flush j=%0d: rdy=%b done=%b, want 0 %b", j, bus_a.in_ready, bus_a.done, (j == N));
      end
      cyc(1'b1, pack4(-5, -6, -7, -8), 1'b1, 1'b0);
    end
    n_tests++;
    if (bus_a.in_ready !== 1'b1 || bus_a.busy !== 1'b0 || bus_a.beat_count !== 9'd2) begin
      n_fail++;
      $display("FAIL hold_idle: rdy=%b busy=%b cnt=%0d, want 1 0 2",
               bus_a.in_ready, bus_a.busy, bus_a.beat_count);
    end
    cyc(1'b1, pack4(-5, -6, -7, -8), 1'b1, 1'b1);
    n_tests++;
    if (bus_a.busy !== 1'b1 || bus_a.in_ready !== 1'b0 || bus_a.beat_count !== 9'd1) begin
      n_fail++;
      $display("FAIL hold_newtile: busy=%b rdy=%b cnt=%0d, want 1 0 1",
               bus_a.busy, bus_a.in_ready, bus_a.beat_count);
    end
    for (int j = 2; j <= N + 1; j++) begin
      idle();
      n_tests++;
      if (bus_a.done !== (j == N) || bus_a.in_ready !== (j > N)) begin
        n_fail++;
        $display("FAIL hold_tail j=%0d: done=%b rdy=%b, want %b %b", j, bus_a.done, bus_a.in_ready, (j == N), (j > N));
      end
    end
  endtask

  task automatic test_overflow();
    for (int b = 0; b < 5; b++) begin
      if (b == 4) begin
        n_tests++;
        if (bus_b.beat_count !== 3'd4 || bus_b.err_overflow !== 1'b0) begin
          n_fail++;
          $display("FAIL ovf_at_max: cnt=%0d err=%b, want 4 0", bus_b.beat_count, bus_b.err_overflow);
        end
      end
      cyc(1'b1, pack4(30 + b, 40 + b, 50 + b, 60 + b), (b == 4), 1'b1);
    end
    n_tests++;
    if (bus_b.beat_count !== 3'd4 || bus_b.err_overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_b: cnt=%0d err=%b, want 4 1", bus_b.beat_count, bus_b.err_overflow);
    end
    n_tests++;
    if (bus_a.beat_count !== 9'd5 || bus_a.err_overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_a: cnt=%0d err=%b, want 5 0", bus_a.beat_count, bus_a.err_overflow);
    end
    for (int j = 0; j < N + 2; j++) idle();
    n_tests++;
    if (bus_b.err_overflow !== 1'b1 || bus_b.busy !== 1'b0 || bus_b.beat_count !== 3'd4) begin
      n_fail++;
      $display("FAIL ovf_sticky: err=%b busy=%b cnt=%0d, want 1 0 4",
               bus_b.err_overflow, bus_b.busy, bus_b.beat_count);
    end
  endtask

  task automatic test_mid_reset();
    cyc(1'b1, pack4(70, 71, 72, 73), 1'b0, 1'b1);
    tb_rst = 1'b1;
    cyc(1'b1, pack4(74, 75, 76, 77), 1'b0, 1'b0);
    tb_rst = 1'b0;
    tb_valid = 1'b0;
    n_tests++;
    if (bus_a.lane_valid !== '0 || bus_a.busy !== 1'b0 || bus_a.in_ready !== 1'b1 ||
        bus_a.done !== 1'b0 || bus_a.beat_count !== '0) begin
      n_fail++;
      $display("FAIL midrst_a: lv=%b busy=%b rdy=%b done=%b cnt=%0d, want 0 0 1 0 0",
               bus_a.lane_valid, bus_a.busy, bus_a.in_ready, bus_a.done, bus_a.beat_count);
    end
    n_tests++;
    if (bus_b.err_overflow !== 1'b0 || bus_b.lane_valid !== '0) begin
      n_fail++;
      $display("FAIL midrst_b: err=%b lv=%b, want 0 0", bus_b.err_overflow, bus_b.lane_valid);
    end
    for (int j = 1; j <= N + 2; j++) begin
      idle();
      n_tests++;
      if (bus_a.done !== 1'b0 || bus_a.busy !== 1'b0) begin
        n_fail++;
        $display("FAIL midrst_nodone j=%0d: done=%b busy=%b, want 0 0", j, bus_a.done, bus_a.busy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_bubble();
    test_single_neg();
    test_flush_hold();
    test_overflow();
    test_mid_reset();
    idle();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
